// File: rtl/otter_pkg.sv
// Shared types for the OTTER ALU source-B stage: select codes, skid-buffer
// states and the buffered entry layout.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        SRCB_RS2   = 3'd0,
        SRCB_ITYPE = 3'd1,
        SRCB_STYPE = 3'd2,
        SRCB_PC    = 3'd3,
        SRCB_CSR   = 3'd4
    } srcb_sel_t;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_FULL
    } skid_st_t;

    // [0] = bypassed from EX, [1] = bypassed from MEM
    typedef logic [1:0] fwd_hit_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        fwd_hit_t        fwd_hit;
    } srcb_ent_t;

endpackage

// File: rtl/srcb_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides and a synchronous flush.
// IN_READY is decoded from the state register only, never from out_ready.
module srcb_skid_buf
    import otter_pkg::*;
#(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_st_t     state, state_nxt;
    logic [W-1:0] head, tail;
    logic         accept, pop;
    logic         load_head, load_tail, shift_tail;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SK_EMPTY;
        else     state <= state_nxt;
    end

    // NOTE: every signal assigned in a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            SK_EMPTY: if (accept) state_nxt = SK_ONE;
            SK_ONE: begin
                if (accept && !pop)      state_nxt = SK_FULL;
                else if (!accept && pop) state_nxt = SK_EMPTY;
            end
            SK_FULL:  if (pop) state_nxt = SK_ONE;
            default:  state_nxt = SK_EMPTY;
        endcase
        if (flush) state_nxt = SK_EMPTY;
    end

    always_comb begin
        in_ready  = (state != SK_FULL);
        out_valid = (state != SK_EMPTY);
    end

    // A replaced or newly-arrived head comes from the input; a drained FULL
    // buffer promotes the second entry.
    assign load_head  = accept && ((state == SK_EMPTY) || (state == SK_ONE && pop));
    assign load_tail  = accept && (state == SK_ONE) && !pop;
    assign shift_tail = pop && (state == SK_FULL);

    // NOTE: the two data registers are reset as well; they are small, and the
    // output is then defined at reset without relying on the valid gating alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head)       head <= in_data;
            else if (shift_tail) head <= tail;
            if (load_tail)       tail <= in_data;
        end
    end

    assign out_data = out_valid ? head : '0;

endmodule

// File: rtl/alu_srcb_stage.sv
// ALU operand-B select with EX/MEM bypass of RS2, registered through a
// two-entry skid buffer; flags illegal select codes with a sticky error.
module alu_srcb_stage
    import otter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3,
    parameter int RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FLUSH,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [SEL_W-1:0]   ALU_SRCB,
    input  logic [WIDTH-1:0]   RS2,
    input  logic [RADDR_W-1:0] RS2_ADDR,
    input  logic [WIDTH-1:0]   I_TYPE,
    input  logic [WIDTH-1:0]   S_TYPE,
    input  logic [WIDTH-1:0]   PC,
    input  logic [WIDTH-1:0]   CSR_RD,
    input  logic               EX_FWD_EN,
    input  logic [RADDR_W-1:0] EX_FWD_ADDR,
    input  logic [WIDTH-1:0]   EX_FWD_DATA,
    input  logic               MEM_FWD_EN,
    input  logic [RADDR_W-1:0] MEM_FWD_ADDR,
    input  logic [WIDTH-1:0]   MEM_FWD_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   SRCB,
    output logic [1:0]         FWD_HIT,
    output logic               SEL_ERR
);

    localparam int ENT_W = WIDTH + 2;

    logic [WIDTH-1:0] rs2_val, sel_data;
    fwd_hit_t         byp_hit, sel_hit;
    logic             sel_bad;
    logic [ENT_W-1:0] buf_out;

    assign sel_bad = (32'(ALU_SRCB) >= NUM_SRC);

    // EX wins over MEM because it holds the younger write; x0 is hardwired zero.
    always_comb begin
        rs2_val = RS2;
        byp_hit = '0;
        if (RS2_ADDR != '0) begin
            if (EX_FWD_EN && EX_FWD_ADDR == RS2_ADDR) begin
                rs2_val = EX_FWD_DATA;
                byp_hit = 2'b01;
            end else if (MEM_FWD_EN && MEM_FWD_ADDR == RS2_ADDR) begin
                rs2_val = MEM_FWD_DATA;
                byp_hit = 2'b10;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_hit  = '0;
        if (!sel_bad) begin
            case (ALU_SRCB)
                SEL_W'(SRCB_RS2): begin
                    sel_data = rs2_val;
                    sel_hit  = byp_hit;
                end
                SEL_W'(SRCB_ITYPE): sel_data = I_TYPE;
                SEL_W'(SRCB_STYPE): sel_data = S_TYPE;
                SEL_W'(SRCB_PC):    sel_data = PC;
                SEL_W'(SRCB_CSR):   sel_data = CSR_RD;
                default:            sel_data = '0;
            endcase
        end
    end

    // Only a real accept sets the flag; an input dropped by FLUSH does not.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                          SEL_ERR <= 1'b0;
        else if (IN_VALID && IN_READY && !FLUSH && sel_bad) SEL_ERR <= 1'b1;
    end

    srcb_skid_buf #(.W(ENT_W)) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .flush     (FLUSH),
        .in_valid  (IN_VALID),
        .in_ready  (IN_READY),
        .in_data   ({sel_data, sel_hit}),
        .out_valid (OUT_VALID),
        .out_ready (OUT_READY),
        .out_data  (buf_out)
    );

    assign {SRCB, FWD_HIT} = buf_out;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Directed bench for alu_srcb_stage: stimulus pushes hand-computed expected
// entries into a queue, an independent monitor pops and compares on each transfer.
module tb_alu_srcb_stage;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, IN_VALID, IN_READY;
    logic [2:0]  ALU_SRCB;
    logic [31:0] RS2, I_TYPE, S_TYPE, PC, CSR_RD;
    logic [4:0]  RS2_ADDR, EX_FWD_ADDR, MEM_FWD_ADDR;
    logic        EX_FWD_EN, MEM_FWD_EN;
    logic [31:0] EX_FWD_DATA, MEM_FWD_DATA;
    logic        OUT_VALID, OUT_READY, SEL_ERR;
    logic [31:0] SRCB;
    logic [1:0]  FWD_HIT;

    int checks = 0;
    int errors = 0;
    srcb_ent_t exp_q[$];

    alu_srcb_stage dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_SRCB(ALU_SRCB), .RS2(RS2), .RS2_ADDR(RS2_ADDR), .I_TYPE(I_TYPE),
        .S_TYPE(S_TYPE), .PC(PC), .CSR_RD(CSR_RD),
        .EX_FWD_EN(EX_FWD_EN), .EX_FWD_ADDR(EX_FWD_ADDR), .EX_FWD_DATA(EX_FWD_DATA),
        .MEM_FWD_EN(MEM_FWD_EN), .MEM_FWD_ADDR(MEM_FWD_ADDR), .MEM_FWD_DATA(MEM_FWD_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SRCB(SRCB), .FWD_HIT(FWD_HIT),
        .SEL_ERR(SEL_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand set, hold it until accepted, record the expected entry.
    task automatic send(input logic [2:0] sel, input logic [31:0] rs2, input logic [4:0] ra,
                        input logic ex_en, input logic [4:0] ex_a, input logic [31:0] ex_d,
                        input logic mem_en, input logic [4:0] mem_a, input logic [31:0] mem_d,
                        input logic [31:0] exp_d, input logic [1:0] exp_h);
        srcb_ent_t e;
        int waited = 0;
        ALU_SRCB = sel; RS2 = rs2; RS2_ADDR = ra;
        EX_FWD_EN = ex_en; EX_FWD_ADDR = ex_a; EX_FWD_DATA = ex_d;
        MEM_FWD_EN = mem_en; MEM_FWD_ADDR = mem_a; MEM_FWD_DATA = mem_d;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: IN_READY stayed 0 for %0d cycles, expected 1", waited);
        end else begin
            e.data = exp_d;
            e.fwd_hit = exp_h;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        EX_FWD_EN = 1'b0;
        MEM_FWD_EN = 1'b0;
    endtask

    // Plain value through RS2 with x0 address, so no bypass can apply.
    task automatic push_val(input logic [31:0] v);
        send(3'd0, v, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, v, 2'b00);
    endtask

    // Monitor: compare every transfer against the queue head.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got SRCB=0x%0h FWD_HIT=%b, expected nothing", SRCB, FWD_HIT);
            end else begin
                srcb_ent_t e;
                e = exp_q.pop_front();
                if (SRCB !== e.data || FWD_HIT !== e.fwd_hit) begin
                    errors++;
                    $display("FAIL output: got SRCB=0x%0h FWD_HIT=%b, expected SRCB=0x%0h FWD_HIT=%b",
                             SRCB, FWD_HIT, e.data, e.fwd_hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        ALU_SRCB = '0; RS2 = 32'hA; RS2_ADDR = '0;
        I_TYPE = 32'h11; S_TYPE = 32'h22; PC = 32'h33; CSR_RD = 32'h44;
        EX_FWD_EN = 1'b0; EX_FWD_ADDR = '0; EX_FWD_DATA = '0;
        MEM_FWD_EN = 1'b0; MEM_FWD_ADDR = '0; MEM_FWD_DATA = '0;

        #12;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_srcb", SRCB, 32'd0);
        check("rst_fwd_hit", 32'(FWD_HIT), 32'd0);
        check("rst_sel_err", 32'(SEL_ERR), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("rst_in_ready", 32'(IN_READY), 32'd1);

        // Select sweep, back to back at full throughput
        OUT_READY = 1'b1;
        send(3'd1, 32'hA, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h11, 2'b00);
        check("latency_valid", 32'(OUT_VALID), 32'd1);
        check("latency_srcb", SRCB, 32'h11);
        send(3'd2, 32'hA, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h22, 2'b00);
        send(3'd3, 32'hA, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h33, 2'b00);
        send(3'd4, 32'hA, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h44, 2'b00);

        // Bypass priority and x0 exclusion; non-RS2 select ignores hits
        send(3'd0, 32'hA, 5'd5, 1'b1, 5'd5, 32'hE, 1'b1, 5'd5, 32'hF, 32'hE, 2'b01);
        send(3'd0, 32'hA, 5'd5, 1'b0, 5'd5, 32'hE, 1'b1, 5'd5, 32'hF, 32'hF, 2'b10);
        send(3'd0, 32'hA, 5'd0, 1'b1, 5'd0, 32'hE, 1'b1, 5'd0, 32'hF, 32'hA, 2'b00);
        send(3'd0, 32'hA, 5'd5, 1'b1, 5'd6, 32'hE, 1'b0, 5'd5, 32'hF, 32'hA, 2'b00);
        send(3'd1, 32'hA, 5'd5, 1'b1, 5'd5, 32'hE, 1'b1, 5'd5, 32'hF, 32'h11, 2'b00);
        repeat (2) @(posedge CLK);
        #1;

        // Backpressure: two accepts fill, third held off until release
        OUT_READY = 1'b0;
        push_val(32'h1);
        push_val(32'h2);
        check("bp_in_ready", 32'(IN_READY), 32'd0);
        fork
            push_val(32'h3);
            begin
                repeat (3) begin
                    @(negedge CLK);
                    check("bp_held_ready", 32'(IN_READY), 32'd0);
                    check("bp_head_stable", SRCB, 32'h1);
                end
                @(posedge CLK); #1;
                OUT_READY = 1'b1;
            end
        join
        repeat (3) @(posedge CLK);
        #1;
        check("bp_drained", 32'(OUT_VALID), 32'd0);

        // Flush from ONE with a same-cycle accept: the accept is dropped
        OUT_READY = 1'b0;
        push_val(32'h7);
        FLUSH = 1'b1; IN_VALID = 1'b1; ALU_SRCB = 3'd0; RS2 = 32'h99; RS2_ADDR = 5'd0;
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        exp_q.delete();
        check("flush1_out_valid", 32'(OUT_VALID), 32'd0);
        check("flush1_in_ready", 32'(IN_READY), 32'd1);

        // Flush from FULL with IN_VALID held high
        push_val(32'h8);
        push_val(32'h9);
        check("full_in_ready", 32'(IN_READY), 32'd0);
        FLUSH = 1'b1; IN_VALID = 1'b1; RS2 = 32'h98;
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        exp_q.delete();
        check("flush2_out_valid", 32'(OUT_VALID), 32'd0);
        check("flush2_in_ready", 32'(IN_READY), 32'd1);
        OUT_READY = 1'b1;
        push_val(32'h55);
        repeat (2) @(posedge CLK);
        #1;

        // Illegal select: zero data, sticky error survives flush
        send(3'd7, 32'hA, 5'd5, 1'b1, 5'd5, 32'hE, 1'b0, 5'd0, 32'd0, 32'h0, 2'b00);
        check("sel_err_set", 32'(SEL_ERR), 32'd1);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        exp_q.delete();
        check("sel_err_after_flush", 32'(SEL_ERR), 32'd1);

        // Async reset between edges with the buffer FULL
        OUT_READY = 1'b0;
        send(3'd0, 32'hA, 5'd5, 1'b1, 5'd5, 32'hE, 1'b0, 5'd0, 32'd0, 32'hE, 2'b01);
        push_val(32'h6);
        check("pre_rst_valid", 32'(OUT_VALID), 32'd1);
        @(negedge CLK); #2;
        RST = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_valid", 32'(OUT_VALID), 32'd0);
        check("arst_srcb", SRCB, 32'd0);
        check("arst_fwd_hit", 32'(FWD_HIT), 32'd0);
        check("arst_sel_err", 32'(SEL_ERR), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_in_ready", 32'(IN_READY), 32'd1);
        check("post_rst_out_valid", 32'(OUT_VALID), 32'd0);

        OUT_READY = 1'b1;
        push_val(32'h77);
        repeat (4) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
